turbo_iter_ctrl: RTL and testbench
==================================

# turbo_iter_ctrl

Parametrised iteration controller and symbol buffer for the turbo decoder datapath. It collects one block of soft input symbols and sequences a configurable number of full iterations. Each full iteration is two half-iterations: an external SISO run in natural order, then one in interleaved order. The block then presents the final hard-decision word through a valid/ready output handshake. It replaces the fixed 8-bit-in / 16-bit-out, fixed-16-iteration decoder top with width, block length and iteration count as run-time or elaboration choices.

## Interface
- DATA_W, 8, soft-symbol width
- BLK_LEN, 16, symbols per block = hard-output width
- MAX_ITER, 16, maximum full iterations
- ITER_W, 5, width of iteration fields, must hold MAX_ITER
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle pulse; starts a frame when idle
- i_iter_num  in  ITER_W  full iterations requested; sampled on accepted i_start
- i_data  in  DATA_W  soft symbol
- i_data_valid  in  1  i_data valid
- o_data_ready  out  1  block accepts symbols (LOAD only)
- i_sym_raddr  in  $clog2(BLK_LEN)  SISO read address into symbol buffer
- o_sym_rdata  out  DATA_W  buffer word at i_sym_raddr, combinational
- o_siso_start  out  1  one-cycle pulse launching a half-iteration
- o_siso_sel  out  1  0 = natural order, 1 = interleaved; stable from pulse until done
- i_siso_done  in  1  half-iteration finished
- i_siso_hard  in  BLK_LEN  hard decisions, valid with i_siso_done
- o_data  out  BLK_LEN  decoded word
- o_valid  out  1  o_data valid
- i_ready  in  1  downstream accepts o_data
- o_iter_used  out  ITER_W  full iterations executed, valid with o_valid
- o_busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, HALF1, WAIT1, HALF2, WAIT2, CHECK, OUT.
- IDLE → LOAD on i_start. Latch the iteration target as 1 if i_iter_num = 0, MAX_ITER if i_iter_num > MAX_ITER, else i_iter_num. Clear the iteration counter and the symbol write pointer.
- LOAD: o_data_ready = 1. Each cycle with i_data_valid high writes buffer[ptr] and increments ptr. When the BLK_LEN-th symbol is accepted → HALF1.
- HALF1: o_siso_start = 1 and o_siso_sel = 0 for one cycle → WAIT1.
- WAIT1: on i_siso_done → HALF2. i_siso_hard is ignored here.
- HALF2: pulse with o_siso_sel = 1 → WAIT2.
- WAIT2: on i_siso_done, capture i_siso_hard into the result register and increment the counter → CHECK.
- CHECK: if counter == target (or early-stop hit) → OUT, else → HALF1. Before leaving, copy the result into the previous-result register.
- OUT: o_valid = 1. o_data and o_iter_used are held stable until i_ready. The handshake completes in the cycle o_valid && i_ready → IDLE.
- i_start outside IDLE is ignored; no queuing.
- i_data_valid outside LOAD is ignored and not written.
- i_siso_done outside WAIT1/WAIT2 is ignored.
- The buffer is not cleared between frames. The read port is always live.

## Timing
- Reset values: o_data_ready = 0, o_siso_start = 0, o_siso_sel = 0, o_data = 0, o_valid = 0, o_iter_used = 0, o_busy = 0. State = IDLE, counter, pointer and both result registers = 0.
- i_start at edge n → o_data_ready = 1 from cycle n+1.
- Last symbol accepted at edge m → o_siso_start at cycle m+1.
- Done in WAIT1 at edge k → next o_siso_start at k+1.
- Done in WAIT2 at edge k → CHECK at k+1, then o_valid at k+2 or o_siso_start at k+2.
- With a zero-latency SISO (done one cycle after start), one full iteration costs 5 cycles.
- i_rst asserted in any state, including mid-handshake with o_valid high, returns all registers to reset values on that edge. The frame is dropped.

## Configuration
- TURBO_EARLY_STOP_EN defined: in CHECK, if counter ≥ 2 and the result equals the previous result, go to OUT early. o_iter_used reports the actual count.
- TURBO_EARLY_STOP_EN undefined: exactly the target iteration count always runs. No previous-result comparator is generated; the previous-result register is still present but unused.

## Structure
- Package turbo_pkg holds:
  - state enum turbo_iter_state_e
  - default parameter constants (DATA_W, BLK_LEN, MAX_ITER)
  - half-iteration select constants SEL_NATURAL = 0 and SEL_INTERLEAVED = 1
- Sub-module turbo_sym_buf: BLK_LEN × DATA_W register file with one synchronous write port and one combinational read port, reset to zero.

## Test plan
- Reset, then idle for 10 cycles: all outputs 0; i_data_valid pulses give o_data_ready = 0 and no buffer write.
- Defaults, i_iter_num = 3. Load 16 symbols 8'h00..8'h0F. SISO model returns 16'hF2CF after 2 cycles. Required: 6 o_siso_start pulses with sel alternating 0,1; o_data = 16'hF2CF; o_iter_used = 3; o_sym_rdata at address 5 = 8'h05.
- i_iter_num = 0, then 31. Required: 1 and 16 full iterations respectively (2 and 32 start pulses).
- Hold i_ready low for 7 cycles after o_valid. Required: o_data and o_iter_used are stable; IDLE is reached one cycle after i_ready rises; a second i_start pulse mid-frame has no effect.
- TURBO_EARLY_STOP_EN, i_iter_num = 16, SISO returns 16'h9C58 every time. Required: o_iter_used = 2. With the macro undefined: o_iter_used = 16.
- Assert i_rst in WAIT2, and again in OUT. Required: all outputs return to 0 on the next edge; a new frame with data 16'h6A4C-producing SISO completes correctly.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared types and defaults for the turbo decoder iteration controller.
package turbo_pkg;

    localparam int unsigned TURBO_DATA_W   = 8;
    localparam int unsigned TURBO_BLK_LEN  = 16;
    localparam int unsigned TURBO_MAX_ITER = 16;

    localparam logic SEL_NATURAL     = 1'b0;
    localparam logic SEL_INTERLEAVED = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_HALF1 = 3'd2,
        S_WAIT1 = 3'd3,
        S_HALF2 = 3'd4,
        S_WAIT2 = 3'd5,
        S_CHECK = 3'd6,
        S_OUT   = 3'd7
    } turbo_iter_state_e;

endpackage

// File: rtl/turbo_sym_buf.sv
// Soft-symbol register file: one synchronous write port, one combinational read port.
module turbo_sym_buf
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration controller: buffers one block, sequences natural/interleaved
// SISO half-iterations, then hands off the hard word. Option: TURBO_EARLY_STOP_EN.
module turbo_iter_ctrl
    import turbo_pkg::*;
#(
    parameter int unsigned DATA_W   = TURBO_DATA_W,
    parameter int unsigned BLK_LEN  = TURBO_BLK_LEN,
    parameter int unsigned MAX_ITER = TURBO_MAX_ITER,
    parameter int unsigned ITER_W   = 5,
    localparam int unsigned ADDR_W  = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1
)(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [ITER_W-1:0]  i_iter_num,
    input  logic [DATA_W-1:0]  i_data,
    input  logic               i_data_valid,
    output logic               o_data_ready,
    input  logic [ADDR_W-1:0]  i_sym_raddr,
    output logic [DATA_W-1:0]  o_sym_rdata,
    output logic               o_siso_start,
    output logic               o_siso_sel,
    input  logic               i_siso_done,
    input  logic [BLK_LEN-1:0] i_siso_hard,
    output logic [BLK_LEN-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [ITER_W-1:0]  o_iter_used,
    output logic               o_busy
);

    localparam logic [2:0] ST_IDLE  = S_IDLE;
    localparam logic [2:0] ST_LOAD  = S_LOAD;
    localparam logic [2:0] ST_HALF1 = S_HALF1;
    localparam logic [2:0] ST_WAIT1 = S_WAIT1;
    localparam logic [2:0] ST_HALF2 = S_HALF2;
    localparam logic [2:0] ST_WAIT2 = S_WAIT2;
    localparam logic [2:0] ST_CHECK = S_CHECK;
    localparam logic [2:0] ST_OUT   = S_OUT;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [ITER_W-1:0]  r_target;
    logic [ITER_W-1:0]  r_iter_cnt;
    logic [ADDR_W-1:0]  r_ptr;
    logic [BLK_LEN-1:0] r_result;
    logic [BLK_LEN-1:0] r_prev;
    logic [ITER_W-1:0]  w_target_in;
    logic               w_wr_en;
    logic               w_last_sym;
    logic               w_early_stop;

    assign w_wr_en    = (r_state == ST_LOAD) && i_data_valid;
    assign w_last_sym = (r_ptr == ADDR_W'(BLK_LEN - 1));

`ifdef TURBO_EARLY_STOP_EN
    // Converged when two consecutive full iterations agree.
    assign w_early_stop = (r_iter_cnt >= ITER_W'(2)) && (r_result == r_prev);
`else
    logic w_unused_prev;
    assign w_unused_prev = ^r_prev;
    assign w_early_stop  = 1'b0;
`endif

    turbo_sym_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (BLK_LEN),
        .ADDR_W (ADDR_W)
    ) u_sym_buf (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr_en (w_wr_en),
        .i_waddr (r_ptr),
        .i_wdata (i_data),
        .i_raddr (i_sym_raddr),
        .o_rdata (o_sym_rdata)
    );

    // Next-state decode and requested-iteration clamp.
    always_comb begin
        w_state_nxt = r_state;
        w_target_in = i_iter_num;
        if (i_iter_num == '0) begin
            w_target_in = ITER_W'(1);
        end else if (i_iter_num > ITER_W'(MAX_ITER)) begin
            w_target_in = ITER_W'(MAX_ITER);
        end

        case (r_state)
            ST_IDLE:  if (i_start) w_state_nxt = ST_LOAD;
            ST_LOAD:  if (i_data_valid && w_last_sym) w_state_nxt = ST_HALF1;
            ST_HALF1: w_state_nxt = ST_WAIT1;
            ST_WAIT1: if (i_siso_done) w_state_nxt = ST_HALF2;
            ST_HALF2: w_state_nxt = ST_WAIT2;
            ST_WAIT2: if (i_siso_done) w_state_nxt = ST_CHECK;
            ST_CHECK: begin
                if ((r_iter_cnt == r_target) || w_early_stop) begin
                    w_state_nxt = ST_OUT;
                end else begin
                    w_state_nxt = ST_HALF1;
                end
            end
            ST_OUT:   if (i_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State, datapath and outputs registered from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_target     <= '0;
            r_iter_cnt   <= '0;
            r_ptr        <= '0;
            r_result     <= '0;
            r_prev       <= '0;
            o_data_ready <= 1'b0;
            o_siso_start <= 1'b0;
            o_siso_sel   <= SEL_NATURAL;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_iter_used  <= '0;
            o_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            o_data_ready <= (w_state_nxt == ST_LOAD);
            o_siso_start <= (w_state_nxt == ST_HALF1) || (w_state_nxt == ST_HALF2);
            o_siso_sel   <= ((w_state_nxt == ST_HALF2) || (w_state_nxt == ST_WAIT2))
                            ? SEL_INTERLEAVED : SEL_NATURAL;
            o_valid      <= (w_state_nxt == ST_OUT);
            o_busy       <= (w_state_nxt != ST_IDLE);

            if ((r_state == ST_IDLE) && i_start) begin
                r_target   <= w_target_in;
                r_iter_cnt <= '0;
                r_ptr      <= '0;
            end

            if (w_wr_en) begin
                r_ptr <= w_last_sym ? '0 : r_ptr + ADDR_W'(1);
            end

            if ((r_state == ST_WAIT2) && i_siso_done) begin
                r_result   <= i_siso_hard;
                r_iter_cnt <= r_iter_cnt + ITER_W'(1);
            end

            if (r_state == ST_CHECK) begin
                r_prev <= r_result;
                if (w_state_nxt == ST_OUT) begin
                    o_data      <= r_result;
                    o_iter_used <= r_iter_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Directed self-checking bench for turbo_iter_ctrl with a behavioural SISO responder.
module tb_turbo_iter_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic [4:0]  i_iter_num = '0;
    logic [7:0]  i_data = '0;
    logic        i_data_valid = 1'b0;
    logic        o_data_ready;
    logic [3:0]  i_sym_raddr = '0;
    logic [7:0]  o_sym_rdata;
    logic        o_siso_start;
    logic        o_siso_sel;
    logic        i_siso_done = 1'b0;
    logic [15:0] i_siso_hard = '0;
    logic [15:0] o_data;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [4:0]  o_iter_used;
    logic        o_busy;

    int n_assert = 0;
    int n_fail   = 0;

    turbo_iter_ctrl dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_iter_num   (i_iter_num),
        .i_data       (i_data),
        .i_data_valid (i_data_valid),
        .o_data_ready (o_data_ready),
        .i_sym_raddr  (i_sym_raddr),
        .o_sym_rdata  (o_sym_rdata),
        .o_siso_start (o_siso_start),
        .o_siso_sel   (o_siso_sel),
        .i_siso_done  (i_siso_done),
        .i_siso_hard  (i_siso_hard),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_iter_used  (o_iter_used),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    // SISO responder: done pulse siso_lat cycles after each start (next cycle when 0).
    int   siso_lat = 2;
    int   starts   = 0;
    int   sel_err  = 0;
    int   cyc      = 0;
    int   siso_cnt = 0;
    logic par      = 1'b0;
    int   start_cyc [64];

    always @(posedge i_clk) begin
        cyc = cyc + 1;
        i_siso_done <= 1'b0;
        if (i_rst) begin
            siso_cnt <= 0;
            par      <= 1'b0;
        end else if (o_siso_start) begin
            if (o_siso_sel !== par) sel_err = sel_err + 1;
            par <= ~par;
            start_cyc[starts % 64] = cyc;
            starts = starts + 1;
            if (siso_lat == 0) i_siso_done <= 1'b1;
            else               siso_cnt <= siso_lat;
        end else if (siso_cnt != 0) begin
            siso_cnt <= siso_cnt - 1;
            if (siso_cnt == 1) i_siso_done <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_frame(input logic [4:0] n);
        i_iter_num = n;
        i_start    = 1'b1;
        tick();
        i_start    = 1'b0;
        check("ready_after_start", 32'(o_data_ready), 32'd1);
    endtask

    task automatic load_block(input logic [7:0] base);
        for (int i = 0; i < 16; i++) begin
            i_data       = base + 8'(i);
            i_data_valid = 1'b1;
            tick();
        end
        i_data_valid = 1'b0;
        check("start_after_last_sym", 32'(o_siso_start), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!o_valid && n < 2000) begin
            tick();
            n++;
        end
        check(tag, 32'(o_valid), 32'd1);
    endtask

    task automatic handshake();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("idle_after_ready", 32'({o_valid, o_busy}), 32'd0);
    endtask

    int   s0;
    int   n;
    logic stable;

    initial begin
        tick();
        tick();
        i_rst = 1'b0;

        // Reset state and idle-time writes ignored.
        check("reset_outputs", 32'({o_busy, o_valid, o_data, o_iter_used,
                                    o_siso_start, o_siso_sel, o_data_ready}), 32'd0);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_data       = 8'hAA;
            i_data_valid = i[0];
            tick();
            if (o_data_ready !== 1'b0 || o_busy !== 1'b0) stable = 1'b0;
        end
        i_data_valid = 1'b0;
        check("idle_ready_busy_low", 32'(stable), 32'd1);
        i_sym_raddr = 4'd3;
        #1;
        check("idle_no_write", 32'(o_sym_rdata), 32'h00);

        // Three iterations, symbols 0..15.
        i_siso_hard = 16'hF2CF;
        siso_lat    = 2;
        s0          = starts;
        start_frame(5'd3);
        check("busy_in_load", 32'(o_busy), 32'd1);
        load_block(8'h00);
        wait_valid("valid_iter3");
        check("starts_iter3", 32'(starts - s0), 32'd6);
        check("sel_alternate", 32'(sel_err), 32'd0);
        check("data_iter3", 32'(o_data), 32'hF2CF);
        check("used_iter3", 32'(o_iter_used), 32'd3);
        i_sym_raddr = 4'd5;
        #1;
        check("rdata_addr5", 32'(o_sym_rdata), 32'h05);
        handshake();

        // Iteration request clamps.
        s0 = starts;
        start_frame(5'd0);
        load_block(8'h10);
        wait_valid("valid_iter0");
        check("starts_iter0", 32'(starts - s0), 32'd2);
        check("used_iter0", 32'(o_iter_used), 32'd1);
        handshake();

        s0 = starts;
        start_frame(5'd31);
        load_block(8'h20);
        wait_valid("valid_iter31");
        check("starts_iter31", 32'(starts - s0), 32'd32);
        check("used_iter31", 32'(o_iter_used), 32'd16);
        handshake();

        // Zero-latency SISO, output stall and ignored mid-frame start.
        i_siso_hard = 16'h1234;
        siso_lat    = 0;
        s0          = starts;
        start_frame(5'd2);
        load_block(8'h30);
        wait_valid("valid_stall");
        check("full_iter_5cyc", 32'(start_cyc[(s0 + 2) % 64] - start_cyc[s0 % 64]), 32'd5);
        stable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            i_start = (i == 3);
            tick();
            if (o_valid !== 1'b1 || o_data !== 16'h1234 || o_iter_used !== 5'd2) stable = 1'b0;
        end
        i_start = 1'b0;
        check("stall_stable", 32'(stable), 32'd1);
        handshake();
        tick();
        check("start_ignored_busy", 32'(o_busy), 32'd0);

        // Early-stop behaviour on a constant SISO answer.
        i_siso_hard = 16'h9C58;
        siso_lat    = 1;
        start_frame(5'd16);
        load_block(8'h40);
        wait_valid("valid_early");
`ifdef TURBO_EARLY_STOP_EN
        check("used_early", 32'(o_iter_used), 32'd2);
`else
        check("used_early", 32'(o_iter_used), 32'd16);
`endif
        check("data_early", 32'(o_data), 32'h9C58);
        handshake();

        // Reset during WAIT2.
        i_siso_hard = 16'hAAAA;
        siso_lat    = 3;
        start_frame(5'd4);
        load_block(8'h50);
        n = 0;
        while (!(o_siso_sel && !o_siso_start) && n < 50) begin
            tick();
            n++;
        end
        check("reached_wait2", 32'(o_siso_sel && !o_siso_start), 32'd1);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("rst_wait2_outputs", 32'({o_busy, o_valid, o_data, o_iter_used,
                                        o_siso_start, o_siso_sel, o_data_ready}), 32'd0);
        check("rst_wait2_buf", 32'(o_sym_rdata), 32'h00);

        i_siso_hard = 16'h6A4C;
        siso_lat    = 2;
        start_frame(5'd1);
        load_block(8'h60);
        wait_valid("valid_after_rst1");
        check("data_after_rst1", 32'(o_data), 32'h6A4C);
        check("used_after_rst1", 32'(o_iter_used), 32'd1);

        // Reset during OUT with o_valid high.
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("rst_out_outputs", 32'({o_busy, o_valid, o_data, o_iter_used,
                                      o_siso_start, o_siso_sel, o_data_ready}), 32'd0);

        start_frame(5'd3);
        load_block(8'h70);
        wait_valid("valid_after_rst2");
        check("data_after_rst2", 32'(o_data), 32'h6A4C);
        check("used_after_rst2", 32'(o_iter_used), 32'd3);
        i_sym_raddr = 4'd15;
        #1;
        check("rdata_addr15", 32'(o_sym_rdata), 32'h7F);
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
